register_file_mp: RTL and testbench

- Parametrised successor to the single-write, two-read core register file.
- Adds a configurable number of read ports and write-through bypass.
- Adds a second write port that retires long-latency results (e.g. the RV32IM divider), with per-register pending (scoreboard) bits.
- Adds a sequential software/debug clear engine.
- Sits between decode (reads), writeback (primary write) and the multi-cycle M-unit (reserve and long write).

---
 rtl/register_file_mp.sv | 150 +++++++++++++++
 tb/tb_register_file_mp.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port register file: configurable read ports with write-through bypass,
// a second write port for long-latency results with per-register pending
// bits, and a sequential clear engine that restores reset contents.
module register_file_mp #(
  parameter int                 DATA_W  = 32,
  parameter int                 ADDR_W  = 5,
  parameter int                 NUM_RD  = 2,
  parameter int                 SP_IDX  = 2,
  parameter logic [DATA_W-1:0]  SP_INIT = 'h0000_7FF0,
  parameter int                 BYPASS  = 1
) (
  input  logic                     Clk_Core,
  input  logic                     Rst_Core_N,
  input  logic [NUM_RD*ADDR_W-1:0] Read_Addr,
  output logic [NUM_RD*DATA_W-1:0] Read_Data,
  output logic [NUM_RD-1:0]        Read_Busy,
  input  logic [ADDR_W-1:0]        Write_Addr,
  input  logic [DATA_W-1:0]        Write_Data,
  input  logic                     Wr_En,
  input  logic                     Rsv_En,
  input  logic [ADDR_W-1:0]        Rsv_Addr,
  input  logic                     Lng_Wr_En,
  input  logic [ADDR_W-1:0]        Lng_Wr_Addr,
  input  logic [DATA_W-1:0]        Lng_Wr_Data,
  input  logic                     Clr_Req,
  output logic                     Clr_Busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int IDX_W = (ADDR_W < 4) ? 4 : ADDR_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("register_file_mp: NUM_RD must be in 1..4");
  end

  logic [DATA_W-1:0] mem_q  [DEPTH];
  logic              pend_q [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic              idle;
  logic              wr_ok, lng_ok, rsv_ok;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_val;

  // Port qualification: address 0 is hardwired and the clear engine owns the array.
  always_comb begin
    idle     = (state_q == ST_IDLE);
    wr_ok    = idle && Wr_En     && (Write_Addr  != '0);
    lng_ok   = idle && Lng_Wr_En && (Lng_Wr_Addr != '0);
    rsv_ok   = idle && Rsv_En    && (Rsv_Addr    != '0);
    clr_addr = idx_q[ADDR_W-1:0];
    clr_val  = (clr_addr == ADDR_W'(SP_IDX)) ? SP_INIT : '0;
  end

  // Clear engine next-state: walk indices 1..DEPTH-1 once per request.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (Clr_Req) begin
          state_d = ST_CLEAR;
          idx_d   = IDX_W'(1);
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear engine state registers.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Array and scoreboard update; later assignments take priority, so the
  // primary port wins data collisions and a reservation beats a completion.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]  <= (i == SP_IDX) ? SP_INIT : '0;
        pend_q[i] <= 1'b0;
      end
    end else if (state_q == ST_CLEAR) begin
      mem_q[clr_addr]  <= clr_val;
      pend_q[clr_addr] <= 1'b0;
    end else begin
      if (lng_ok) begin
        mem_q[Lng_Wr_Addr]  <= Lng_Wr_Data;
        pend_q[Lng_Wr_Addr] <= 1'b0;
      end
      if (wr_ok) begin
        mem_q[Write_Addr] <= Write_Data;
      end
      if (rsv_ok) begin
        pend_q[Rsv_Addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdata;
    logic              rbusy;

    assign ra = Read_Addr[k*ADDR_W +: ADDR_W];

    // Combinational read with optional forwarding of this cycle's writes.
    always_comb begin
      rdata = mem_q[ra];
      rbusy = pend_q[ra];
      if (BYPASS != 0) begin
        if (wr_ok && (Write_Addr == ra)) begin
          rdata = Write_Data;
        end else if (lng_ok && (Lng_Wr_Addr == ra)) begin
          rdata = Lng_Wr_Data;
        end
        if (lng_ok && (Lng_Wr_Addr == ra)) begin
          rbusy = 1'b0;
        end
      end
      if (ra == '0) begin
        rdata = '0;
        rbusy = 1'b0;
      end
    end

    assign Read_Data[k*DATA_W +: DATA_W] = rdata;
    assign Read_Busy[k]                  = rbusy;
  end

  assign Clr_Busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised and directed checks of register_file_mp (BYPASS=1 and BYPASS=0
// instances sharing stimulus) against a behavioural array model.
module tb_register_file_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  busy_b, busy_n;
  logic [4:0]  wr_addr, rsv_addr, lng_addr;
  logic [31:0] wr_data, lng_data;
  logic        wr_en, rsv_en, lng_en, clr_req;
  logic        clr_busy_b, clr_busy_n;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] m_mem  [32];
  bit          m_pend [32];
  bit          m_clr;
  int unsigned m_idx;

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .SP_IDX(2),
                     .SP_INIT(32'h0000_7FF0), .BYPASS(1)) u_dut_byp (
    .Clk_Core(clk), .Rst_Core_N(rst_n),
    .Read_Addr(rd_addr), .Read_Data(rdata_b), .Read_Busy(busy_b),
    .Write_Addr(wr_addr), .Write_Data(wr_data), .Wr_En(wr_en),
    .Rsv_En(rsv_en), .Rsv_Addr(rsv_addr),
    .Lng_Wr_En(lng_en), .Lng_Wr_Addr(lng_addr), .Lng_Wr_Data(lng_data),
    .Clr_Req(clr_req), .Clr_Busy(clr_busy_b)
  );

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .SP_IDX(2),
                     .SP_INIT(32'h0000_7FF0), .BYPASS(0)) u_dut_nob (
    .Clk_Core(clk), .Rst_Core_N(rst_n),
    .Read_Addr(rd_addr), .Read_Data(rdata_n), .Read_Busy(busy_n),
    .Write_Addr(wr_addr), .Write_Data(wr_data), .Wr_En(wr_en),
    .Rsv_En(rsv_en), .Rsv_Addr(rsv_addr),
    .Lng_Wr_En(lng_en), .Lng_Wr_Addr(lng_addr), .Lng_Wr_Data(lng_data),
    .Clr_Req(clr_req), .Clr_Busy(clr_busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = (i == 2) ? 32'h0000_7FF0 : 32'h0;
      m_pend[i] = 1'b0;
    end
    m_clr = 1'b0;
    m_idx = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && !m_clr) begin
      if (wr_en && wr_addr == a) return wr_data;
      if (lng_en && lng_addr == a) return lng_data;
    end
    return m_mem[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && !m_clr && lng_en && lng_addr == a) return 32'h0;
    return {31'h0, m_pend[a]};
  endfunction

  task automatic check_all();
    logic [4:0] a;
    for (int k = 0; k < 2; k++) begin
      a = rd_addr[k*5 +: 5];
      check_eq($sformatf("rd_byp%0d[x%0d]", k, a), rdata_b[k*32 +: 32], exp_rd(a, 1'b1));
      check_eq($sformatf("rd_nob%0d[x%0d]", k, a), rdata_n[k*32 +: 32], exp_rd(a, 1'b0));
      check_eq($sformatf("busy_byp%0d[x%0d]", k, a), {31'h0, busy_b[k]}, exp_busy(a, 1'b1));
      check_eq($sformatf("busy_nob%0d[x%0d]", k, a), {31'h0, busy_n[k]}, exp_busy(a, 1'b0));
    end
    check_eq("clr_busy_byp", {31'h0, clr_busy_b}, {31'h0, m_clr});
    check_eq("clr_busy_nob", {31'h0, clr_busy_n}, {31'h0, m_clr});
  endtask

  // Applies the architectural effect of one clock edge with the current inputs.
  task automatic model_step();
    if (!rst_n) return;
    if (m_clr) begin
      m_mem[m_idx]  = (m_idx == 2) ? 32'h0000_7FF0 : 32'h0;
      m_pend[m_idx] = 1'b0;
      if (m_idx == 31) m_clr = 1'b0;
      m_idx++;
    end else begin
      if (lng_en && lng_addr != 5'd0) begin
        m_mem[lng_addr]  = lng_data;
        m_pend[lng_addr] = 1'b0;
      end
      if (wr_en && wr_addr != 5'd0) m_mem[wr_addr] = wr_data;
      if (rsv_en && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
      if (clr_req) begin
        m_clr = 1'b1;
        m_idx = 1;
      end
    end
  endtask

  task automatic tick();
    #2;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    wr_en = 1'b0; rsv_en = 1'b0; lng_en = 1'b0; clr_req = 1'b0;
    wr_addr = 5'd0; rsv_addr = 5'd0; lng_addr = 5'd0;
    wr_data = 32'h0; lng_data = 32'h0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic sweep();
    idle_in();
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      tick();
    end
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  int unsigned busy_cycles;

  initial begin
    rst_n = 1'b0;
    idle_in();
    set_rd(0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset contents
    set_rd(2, 0); #1;
    check_eq("rst_x2", rdata_b[31:0], 32'h0000_7FF0);
    check_eq("rst_x0", rdata_b[63:32], 32'h0);
    check_eq("rst_busy", {30'h0, busy_b}, 32'h0);
    check_eq("rst_clr_busy", {31'h0, clr_busy_b}, 32'h0);
    tick();
    set_rd(1, 31); #1;
    check_eq("rst_x1", rdata_b[31:0], 32'h0);
    check_eq("rst_x31", rdata_b[63:32], 32'h0);
    tick();
    sweep();

    // Same-cycle forwarding of a primary write
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; set_rd(5, 5); #1;
    check_eq("byp_x5", rdata_b[31:0], 32'hDEAD_BEEF);
    check_eq("nob_x5_old", rdata_n[31:0], 32'h0);
    tick();
    idle_in(); #1;
    check_eq("nob_x5_new", rdata_n[31:0], 32'hDEAD_BEEF);
    tick();

    // Scoreboard: reserve, complete, simultaneous reserve+complete
    rsv_en = 1'b1; rsv_addr = 5'd7; set_rd(7, 0); #1;
    check_eq("rsv7_same_cycle", {31'h0, busy_b[0]}, 32'h0);
    tick();
    idle_in(); #1;
    check_eq("rsv7_busy", {31'h0, busy_b[0]}, 32'h1);
    tick();
    lng_en = 1'b1; lng_addr = 5'd7; lng_data = 32'h10; #1;
    check_eq("lng7_busy_masked", {31'h0, busy_b[0]}, 32'h0);
    check_eq("lng7_data_fwd", rdata_b[31:0], 32'h10);
    check_eq("lng7_busy_nob", {31'h0, busy_n[0]}, 32'h1);
    tick();
    idle_in(); #1;
    check_eq("lng7_pend_clear", {31'h0, busy_b[0]}, 32'h0);
    tick();
    rsv_en = 1'b1; rsv_addr = 5'd7; lng_en = 1'b1; lng_addr = 5'd7; lng_data = 32'h10;
    tick();
    idle_in(); #1;
    check_eq("rsvlng7_data", rdata_n[31:0], 32'h10);
    check_eq("rsvlng7_pend", {31'h0, busy_b[0]}, 32'h1);
    tick();

    // Primary and long write colliding on x9
    rsv_en = 1'b1; rsv_addr = 5'd9; set_rd(9, 9);
    tick();
    idle_in();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
    lng_en = 1'b1; lng_addr = 5'd9; lng_data = 32'h2; #1;
    check_eq("coll9_fwd", rdata_b[31:0], 32'h1);
    tick();
    idle_in(); #1;
    check_eq("coll9_data", rdata_n[31:0], 32'h1);
    check_eq("coll9_pend", {31'h0, busy_n[0]}, 32'h0);
    tick();

    // Sequential clear
    for (int a = 1; a < 32; a++) begin
      idle_in(); wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'hFFFF_FFFF; set_rd(a, 0);
      tick();
    end
    idle_in(); rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    idle_in(); clr_req = 1'b1;
    tick();
    busy_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      idle_in();
      set_rd(4, 3);
      if (c == 5) begin
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h5;
        lng_en = 1'b1; lng_addr = 5'd6; lng_data = 32'h6;
        rsv_en = 1'b1; rsv_addr = 5'd8; clr_req = 1'b1;
      end
      #1;
      if (!clr_busy_b) break;
      busy_cycles++;
      tick();
    end
    check_eq("clr_cycles", busy_cycles, 32'd31);
    idle_in(); set_rd(4, 3); #1;
    check_eq("clr_x4", rdata_b[31:0], 32'h0);
    check_eq("clr_pend3", {31'h0, busy_b[1]}, 32'h0);
    tick();
    set_rd(2, 31); #1;
    check_eq("clr_x2", rdata_b[31:0], 32'h0000_7FF0);
    check_eq("clr_x31", rdata_b[63:32], 32'h0);
    tick();
    sweep();

    // Reset asserted in the middle of a clear
    for (int a = 1; a < 32; a++) begin
      idle_in(); wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'h1234_0000 + 32'(a);
      tick();
    end
    idle_in(); clr_req = 1'b1;
    tick();
    idle_in();
    repeat (9) tick();
    #2;
    check_eq("midclr_busy_before", {31'h0, clr_busy_b}, 32'h1);
    rst_n = 1'b0; #1;
    check_eq("midclr_busy_byp", {31'h0, clr_busy_b}, 32'h0);
    check_eq("midclr_busy_nob", {31'h0, clr_busy_n}, 32'h0);
    model_reset();
    @(negedge clk);
    sweep();
    rst_n = 1'b1;
    sweep();

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = pick();
      wr_data  = $urandom;
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = pick();
      lng_en   = ($urandom_range(0, 2) == 0);
      lng_addr = pick();
      lng_data = $urandom;
      clr_req  = ($urandom_range(0, 149) == 0);
      rd_addr  = {pick(), pick()};
      tick();
    end
    sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
